memory_access_arbiter: RTL and testbench

MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

---
 rtl/memory_access_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_memory_access_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_arbiter.sv
// Two-requester memory access arbiter in front of a load/store memory controller.
// Optional round-robin contention handling via `MEMORY_ARBITER_ROUND_ROBIN_EN (default: fixed req0 priority).
package memoryAccessArbiterPkg;
    typedef enum logic [1:0] {
        LOAD          = 2'd0,
        STORE_PRELOAD = 2'd1,
        STORE         = 2'd2
    } MemoryMode_t;
endpackage

module memory_access_arbiter
    import memoryAccessArbiterPkg::*;
#(
    parameter int LOAD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [2:0]  req0_funct3,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_imm,
    input  logic [31:0] req0_wdata,
    output logic        req0_done,
    output logic [31:0] req0_rdata,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [2:0]  req1_funct3,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_imm,
    input  logic [31:0] req1_wdata,
    output logic        req1_done,
    output logic [31:0] req1_rdata,

    output MemoryMode_t memoryMode,
    output logic [2:0]  funct3,
    output logic [31:0] rs1,
    output logic [31:0] immediateI,
    output logic [31:0] immediateS,
    output logic [31:0] rs2,
    input  logic [31:0] memoryOutput
);

    typedef enum logic [1:0] {
        stateIdle,
        stateLoadWait,
        statePreload,
        stateStore
    } State_t;

    localparam logic [2:0] WAIT_LAST = 3'(LOAD_LATENCY - 1);

    State_t      stateReg, stateNext;
    logic [2:0]  waitCountReg;
    logic        grantedReg;
    logic        grantIdx;
    logic        grantValid;
    logic        loadFinish;

    logic [1:0]  reqValid, reqWrite, reqReady, reqDone;
    logic [2:0]  reqFunct3 [2];
    logic [31:0] reqRs1    [2];
    logic [31:0] reqImm    [2];
    logic [31:0] reqWdata  [2];
    logic [31:0] reqRdata  [2];

    assign reqValid     = {req1_valid, req0_valid};
    assign reqWrite     = {req1_write, req0_write};
    assign reqFunct3[0] = req0_funct3;
    assign reqFunct3[1] = req1_funct3;
    assign reqRs1[0]    = req0_rs1;
    assign reqRs1[1]    = req1_rs1;
    assign reqImm[0]    = req0_imm;
    assign reqImm[1]    = req1_imm;
    assign reqWdata[0]  = req0_wdata;
    assign reqWdata[1]  = req1_wdata;

    assign grantValid = (stateReg == stateIdle) && (|reqValid);
    assign loadFinish = (stateReg == stateLoadWait) && (waitCountReg == WAIT_LAST);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic lastGrantReg;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grantIdx = ~reqValid[0];
        if (&reqValid) begin
            grantIdx = ~lastGrantReg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGrantReg <= 1'b1;
        end else if (grantValid) begin
            lastGrantReg <= grantIdx;
        end
    end
`else
    assign grantIdx = ~reqValid[0];
`endif

    always_comb begin
        stateNext  = stateReg;
        memoryMode = LOAD;
        case (stateReg)
            stateIdle: begin
                if (grantValid) begin
                    if (!reqWrite[grantIdx]) begin
                        stateNext = stateLoadWait;
                    end else if (reqFunct3[grantIdx][1:0] == 2'b10) begin
                        stateNext = stateStore;
                    end else begin
                        stateNext = statePreload;
                    end
                end
            end
            stateLoadWait: begin
                if (waitCountReg == WAIT_LAST) begin
                    stateNext = stateIdle;
                end
            end
            statePreload: begin
                memoryMode = STORE_PRELOAD;
                stateNext  = stateStore;
            end
            stateStore: begin
                memoryMode = STORE;
                stateNext  = stateIdle;
            end
            default: stateNext = stateIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg     <= stateIdle;
            waitCountReg <= '0;
            grantedReg   <= 1'b0;
            funct3       <= '0;
            rs1          <= '0;
            immediateI   <= '0;
            immediateS   <= '0;
            rs2          <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == stateLoadWait && !loadFinish) begin
                waitCountReg <= waitCountReg + 3'd1;
            end else begin
                waitCountReg <= '0;
            end
            // Memory-side fields only move on accept and otherwise hold.
            if (grantValid) begin
                grantedReg <= grantIdx;
                funct3     <= reqFunct3[grantIdx];
                rs1        <= reqRs1[grantIdx];
                if (reqWrite[grantIdx]) begin
                    immediateS <= reqImm[grantIdx];
                    rs2        <= reqWdata[grantIdx];
                end else begin
                    immediateI <= reqImm[grantIdx];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gReq
            logic        loadDoneReg;
            logic [31:0] rdataReg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    loadDoneReg <= 1'b0;
                    rdataReg    <= '0;
                end else begin
                    loadDoneReg <= loadFinish && (grantedReg == 1'(gi));
                    if (loadFinish && (grantedReg == 1'(gi))) begin
                        rdataReg <= memoryOutput;
                    end
                end
            end

            assign reqReady[gi] = grantValid && (grantIdx == 1'(gi));
            assign reqDone[gi]  = loadDoneReg ||
                                  ((stateReg == stateStore) && (grantedReg == 1'(gi)));
            assign reqRdata[gi] = rdataReg;
        end
    endgenerate

    assign req0_ready = reqReady[0];
    assign req1_ready = reqReady[1];
    assign req0_done  = reqDone[0];
    assign req1_done  = reqDone[1];
    assign req0_rdata = reqRdata[0];
    assign req1_rdata = reqRdata[1];

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Scoreboard bench for memory_access_arbiter: the driver queues expected grants and
// completions, a monitor pops and compares whenever ready or done appears.
module tb_memory_access_arbiter;
    import memoryAccessArbiterPkg::*;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [2:0]  req0_funct3 = '0;
    logic [31:0] req0_rs1 = '0, req0_imm = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [2:0]  req1_funct3 = '0;
    logic [31:0] req1_rs1 = '0, req1_imm = '0, req1_wdata = '0;
    logic        req0_ready, req0_done, req1_ready, req1_done;
    logic [31:0] req0_rdata, req1_rdata;
    MemoryMode_t memoryMode;
    logic [2:0]  funct3;
    logic [31:0] rs1, immediateI, immediateS, rs2, memoryOutput;

    memory_access_arbiter #(.LOAD_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_funct3(req0_funct3), .req0_rs1(req0_rs1), .req0_imm(req0_imm),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_funct3(req1_funct3), .req1_rs1(req1_rs1), .req1_imm(req1_imm),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .memoryMode(memoryMode), .funct3(funct3), .rs1(rs1),
        .immediateI(immediateI), .immediateS(immediateS), .rs2(rs2),
        .memoryOutput(memoryOutput)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Load data is only correct in the cycle the arbiter is expected to sample it.
    int          loadDataCyc = -1;
    logic [31:0] loadData = '0;
    assign memoryOutput = (cyc == loadDataCyc) ? loadData : 32'hBAD0_BAD0;

    typedef struct {
        int          who;
        int          doneCyc;
        bit          isLoad;
        logic [31:0] rdata;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] wdata;
    } Exp_t;

    Exp_t doneQ[$];
    int   grantQ[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every grant and completion against the queues.
    always @(negedge clock) begin
        #2;
        if (reset) begin
            if (req0_ready || req1_ready) begin
                if (grantQ.size() == 0) begin
                    chk("unexpected_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
                end else begin
                    int w;
                    w = grantQ.pop_front();
                    chk("grant_who", {30'd0, req1_ready, req0_ready}, 32'(1 << w));
                    $display("cycle %0d: grant req%0d", cyc, w);
                end
            end
            if (req0_done || req1_done) begin
                if (doneQ.size() == 0) begin
                    chk("unexpected_done", {30'd0, req1_done, req0_done}, 32'd0);
                end else begin
                    Exp_t e;
                    e = doneQ.pop_front();
                    chk("done_who", {30'd0, req1_done, req0_done}, 32'(1 << e.who));
                    chk("done_cycle", 32'(cyc), 32'(e.doneCyc));
                    chk("done_rs1", rs1, e.rs1);
                    if (e.isLoad) begin
                        chk("load_mode", 32'(memoryMode), 32'(LOAD));
                        chk("load_immI", immediateI, e.imm);
                        chk("load_rdata", (e.who == 1) ? req1_rdata : req0_rdata, e.rdata);
                        chk("load_other_done", 32'((e.who == 1) ? req0_done : req1_done), 32'd0);
                    end else begin
                        chk("store_mode", 32'(memoryMode), 32'(STORE));
                        chk("store_immS", immediateS, e.imm);
                        chk("store_rs2", rs2, e.wdata);
                    end
                    $display("cycle %0d: done req%0d %s", cyc, e.who, e.isLoad ? "load" : "store");
                end
            end
        end
    end

    task automatic setReq(input int who, input bit v, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] imm, input logic [31:0] wd);
        if (who == 0) begin
            req0_valid = v; req0_write = wr; req0_funct3 = f3;
            req0_rs1 = a; req0_imm = imm; req0_wdata = wd;
        end else begin
            req1_valid = v; req1_write = wr; req1_funct3 = f3;
            req1_rs1 = a; req1_imm = imm; req1_wdata = wd;
        end
    endtask

    // Issue one request, wait for its accept, queue the expected completion and
    // scramble the inputs right after accept so late changes must be ignored.
    task automatic issue(input int who, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] imm, input logic [31:0] wd,
                         input logic [31:0] data, input bit expectDone, output int acceptCyc);
        Exp_t e;
        bit   accepted;
        accepted = 1'b0;
        @(negedge clock);
        setReq(who, 1'b1, wr, f3, a, imm, wd);
        grantQ.push_back(who);
        for (int n = 0; n < 30; n++) begin
            #1;
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("accepted", 32'(accepted), 32'd1);
        acceptCyc = cyc;
        chk("accept_mode", 32'(memoryMode), 32'(LOAD));
        if (accepted && expectDone) begin
            e.who = who; e.isLoad = !wr; e.rdata = data;
            e.rs1 = a; e.imm = imm; e.wdata = wd;
            if (!wr) begin
                e.doneCyc   = acceptCyc + LAT + 1;
                loadDataCyc = acceptCyc + LAT;
                loadData    = data;
            end else if (f3[1:0] == 2'b10) begin
                e.doneCyc = acceptCyc + 1;
            end else begin
                e.doneCyc = acceptCyc + 2;
            end
            doneQ.push_back(e);
        end
        @(negedge clock);
        setReq(who, 1'b0, wr, ~f3, ~a, ~imm, ~wd);
    endtask

    initial begin
        int t;
        int expWho;
        bit got;
        Exp_t e;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        int last;
`endif

        #7;
        chk("rst_mode", 32'(memoryMode), 32'(LOAD));
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
        chk("rst_rdata0", req0_rdata, 32'd0);
        chk("rst_rdata1", req1_rdata, 32'd0);
        chk("rst_funct3", {29'd0, funct3}, 32'd0);
        chk("rst_rs1", rs1, 32'd0);
        chk("rst_immI", immediateI, 32'd0);
        chk("rst_immS", immediateS, 32'd0);
        chk("rst_rs2", rs2, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Word store from req0
        issue(0, 1'b1, 3'b010, 32'h100, 32'd4, 32'hDEAD_BEEF, 32'd0, 1'b1, t);
        #1 chk("word_store_mode", 32'(memoryMode), 32'(STORE));

        // Byte store from req1: LOAD, STORE_PRELOAD, STORE
        issue(1, 1'b1, 3'b000, 32'h200, 32'd8, 32'h0000_00A5, 32'd0, 1'b1, t);
        #1 chk("byte_preload_mode", 32'(memoryMode), 32'(STORE_PRELOAD));

        // Load from req0; req1 shows up briefly while busy and withdraws before IDLE
        issue(0, 1'b0, 3'b010, 32'h300, 32'h10, 32'd0, 32'h1234_5678, 1'b1, t);
        setReq(1, 1'b1, 1'b1, 3'b010, 32'h777, 32'd0, 32'h7777_7777);
        #1 chk("load_wait_rs1", rs1, 32'h300);
        chk("load_wait_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clock);
        setReq(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        repeat (4) @(negedge clock);
        #1 chk("rdata0_hold", req0_rdata, 32'h1234_5678);
        chk("rdata1_untouched", req1_rdata, 32'd0);

        // Load from req1 must not disturb req0's result
        issue(1, 1'b0, 3'b100, 32'h340, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b1, t);
        repeat (4) @(negedge clock);
        #1 chk("rdata0_hold2", req0_rdata, 32'h1234_5678);
        chk("rdata1_hold", req1_rdata, 32'hCAFE_F00D);

        // Reset during PRELOAD: no STORE cycle may follow
        issue(0, 1'b1, 3'b001, 32'h600, 32'd2, 32'h0000_BEEF, 32'd0, 1'b0, t);
        #1 chk("pre_reset_mode", 32'(memoryMode), 32'(STORE_PRELOAD));
        #2 reset = 1'b0;
        #1 chk("reset_mode_now", 32'(memoryMode), 32'(LOAD));
        chk("reset_rs2", rs2, 32'd0);
        chk("reset_rdata0", req0_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("no_store_after_reset", 32'(memoryMode), 32'(LOAD));
        issue(1, 1'b1, 3'b010, 32'h700, 32'd12, 32'h5555_AAAA, 32'd0, 1'b1, t);

        // Contention from a fresh reset, both requesters held valid
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        last = 1;
`endif
        setReq(0, 1'b1, 1'b1, 3'b010, 32'h400, 32'd0, 32'h1111_0000);
        setReq(1, 1'b1, 1'b1, 3'b010, 32'h500, 32'd4, 32'h2222_0000);
        for (int k = 0; k < 3; k++) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            expWho = (last == 1) ? 0 : 1;
            last = expWho;
`else
            expWho = 0;
`endif
            grantQ.push_back(expWho);
            got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            chk("contention_accept", 32'(got), 32'd1);
            e.who = expWho; e.isLoad = 1'b0; e.rdata = '0; e.doneCyc = cyc + 1;
            e.rs1   = (expWho == 0) ? 32'h400 : 32'h500;
            e.imm   = (expWho == 0) ? 32'd0 : 32'd4;
            e.wdata = (expWho == 0) ? 32'h1111_0000 : 32'h2222_0000;
            if (got) doneQ.push_back(e);
            @(negedge clock);
        end
        setReq(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        setReq(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);

        for (int n = 0; n < 50; n++) begin
            if (doneQ.size() == 0 && grantQ.size() == 0) break;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
        chk("pending_done", 32'(doneQ.size()), 32'd0);
        chk("pending_grant", 32'(grantQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
